multdiv_iter: RTL and testbench

//  Iterative 32-bit signed multiply/divide unit for the processor execute stage.

---
 rtl/multdiv_iter_pkg.sv | 46 ++++
 rtl/multdiv_iter_cla_adder.sv | 36 +++
 rtl/multdiv_iter.sv | 185 ++++++++++++++++++
 tb/tb_multdiv_iter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: state encoding,
// iteration constants, Booth pair codes and carry-free helper functions.
package multdiv_iter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MULT = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam int         ITER_COUNT = 32;
    localparam logic [5:0] LAST_ITER  = 6'(ITER_COUNT - 1);

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    // Two's complement negate without an adder: bits above the lowest set bit flip.
    function automatic logic [31:0] negate32(input logic [31:0] x);
        logic [31:0] r;
        logic        seen;
        seen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[i] ^ seen;
            seen = seen | x[i];
        end
        return r;
    endfunction

    function automatic logic [31:0] magnitude32(input logic [31:0] x);
        return x[31] ? negate32(x) : x;
    endfunction

    function automatic logic [5:0] increment6(input logic [5:0] x);
        logic [5:0] r;
        logic       carry;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            r[i]  = x[i] ^ carry;
            carry = carry & x[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/multdiv_iter_cla_adder.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups with group carries
// chained from each group's generate/propagate terms.
module cla_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = c_in;
        for (int grp = 0; grp < 8; grp++) begin
            c[grp*4+1] = g[grp*4] | (p[grp*4] & c[grp*4]);
            c[grp*4+2] = g[grp*4+1] | (p[grp*4+1] & g[grp*4])
                       | (p[grp*4+1] & p[grp*4] & c[grp*4]);
            c[grp*4+3] = g[grp*4+2] | (p[grp*4+2] & g[grp*4+1])
                       | (p[grp*4+2] & p[grp*4+1] & g[grp*4])
                       | (p[grp*4+2] & p[grp*4+1] & p[grp*4] & c[grp*4]);
            c[grp*4+4] = g[grp*4+3] | (p[grp*4+3] & g[grp*4+2])
                       | (p[grp*4+3] & p[grp*4+2] & g[grp*4+1])
                       | (p[grp*4+3] & p[grp*4+2] & p[grp*4+1] & g[grp*4])
                       | (p[grp*4+3] & p[grp*4+2] & p[grp*4+1] & p[grp*4] & c[grp*4]);
        end
        sum   = p ^ c[31:0];
        c_out = c[32];
    end

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiply (radix-2 Booth) and divide (non-restoring
// on magnitudes) sharing a single cla_adder; result pulses out in DONE.
module multdiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    import multdiv_iter_pkg::*;

    state_e      state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [32:0] acc_q, acc_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] m_q, m_d;
    logic        qm1_q, qm1_d;
    logic        neg_q, neg_d;
    logic        dovf_q, dovf_d;
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;

    logic [31:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    logic        a_ext, b_ext;
    logic [32:0] sum33;

    cla_adder u_adder (
        .a     (add_a),
        .b     (add_b),
        .c_in  (add_cin),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    // The true 33rd sum bit recovers the sign that a 32-bit add can lose.
    assign sum33 = {a_ext ^ b_ext ^ add_cout, add_sum};

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        a_ext   = 1'b0;
        b_ext   = 1'b0;
        case (state_q)
            ST_MULT: begin
                add_a = acc_q[31:0];
                a_ext = acc_q[32];
                case ({lo_q[0], qm1_q})
                    BOOTH_ADD: begin
                        add_b = m_q;
                        b_ext = m_q[31];
                    end
                    BOOTH_SUB: begin
                        add_b   = ~m_q;
                        b_ext   = ~m_q[31];
                        add_cin = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_DIV: begin
                add_a = {acc_q[30:0], lo_q[31]};
                a_ext = acc_q[31];
                if (acc_q[32]) begin
                    add_b = m_q;
                end else begin
                    add_b   = ~m_q;
                    b_ext   = 1'b1;
                    add_cin = 1'b1;
                end
            end
            ST_FIX: begin
                add_a   = neg_q ? ~lo_q : lo_q;
                add_cin = neg_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        m_d      = m_q;
        qm1_d    = qm1_q;
        neg_d    = neg_q;
        dovf_d   = dovf_q;
        result_d = result_q;
        exc_d    = exc_q;
        if (ctrl_MULT) begin
            state_d = ST_MULT;
            count_d = '0;
            acc_d   = '0;
            lo_d    = data_operandB;
            m_d     = data_operandA;
            qm1_d   = 1'b0;
        end else if (ctrl_DIV) begin
            count_d = '0;
            acc_d   = '0;
            qm1_d   = 1'b0;
            if (data_operandB == '0) begin
                state_d  = ST_DONE;
                result_d = '0;
                exc_d    = 1'b1;
            end else begin
                state_d = ST_DIV;
                lo_d    = magnitude32(data_operandA);
                m_d     = magnitude32(data_operandB);
                neg_d   = data_operandA[31] ^ data_operandB[31];
                dovf_d  = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
            end
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_MULT: begin
                    acc_d   = {sum33[32], sum33[32:1]};
                    lo_d    = {sum33[0], lo_q[31:1]};
                    qm1_d   = lo_q[0];
                    count_d = increment6(count_q);
                    // After the final shift, sum33 is exactly product bits [63:31].
                    if (count_q == LAST_ITER) begin
                        state_d  = ST_DONE;
                        result_d = {sum33[0], lo_q[31:1]};
                        exc_d    = ~((&sum33) | ~(|sum33));
                    end
                end
                ST_DIV: begin
                    acc_d   = sum33;
                    lo_d    = {lo_q[30:0], ~sum33[32]};
                    count_d = increment6(count_q);
                    if (count_q == LAST_ITER) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_d  = ST_DONE;
                    result_d = add_sum;
                    exc_d    = dovf_q;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            qm1_q    <= 1'b0;
            neg_q    <= 1'b0;
            dovf_q   <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
            qm1_q    <= qm1_d;
            neg_q    <= neg_d;
            dovf_q   <= dovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == ST_DONE);

endmodule

// File: tb/tb_multdiv_iter.sv
// Self-checking bench for multdiv_iter: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_multdiv_iter;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    multdiv_iter #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Reference behaviour from signed arithmetic; lat is the RDY cycle after start.
    function automatic void refModel(input bit isMult, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] res, output logic exc, output int lat);
        longint prod;
        int     sa;
        int     sb;
        sa = int'(a);
        sb = int'(b);
        if (isMult) begin
            prod = longint'(sa) * longint'(sb);
            res  = prod[31:0];
            exc  = (prod != longint'(int'(prod[31:0])));
            lat  = 33;
        end else if (b == 32'd0) begin
            res = 32'd0;
            exc = 1'b1;
            lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = a;
            exc = 1'b1;
            lat = 34;
        end else begin
            res = 32'(sa / sb);
            exc = 1'b0;
            lat = 34;
        end
    endfunction

    // Called at a negedge; leaves the caller at the negedge of cycle 1.
    task automatic applyStimulus(input bit doMult, input bit doDiv, input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = doMult;
        ctrl_DIV      = doDiv;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic checkOutput(input string tag, input int expLat, input logic [31:0] expRes, input logic expExc);
        int cyc;
        cyc = 1;
        while (data_resultRDY !== 1'b1 && cyc < 80) begin
            @(negedge clock);
            cyc++;
        end
        checkValue({tag, ".lat"}, 32'(cyc), 32'(expLat));
        checkValue({tag, ".res"}, data_result, expRes);
        checkValue({tag, ".exc"}, {31'd0, data_exception}, {31'd0, expExc});
        @(negedge clock);
        checkValue({tag, ".pulse"}, {31'd0, data_resultRDY}, 32'd0);
    endtask

    task automatic runModelOp(input string tag, input bit isMult, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        logic        exc;
        int          lat;
        refModel(isMult, a, b, res, exc, lat);
        applyStimulus(isMult, !isMult, a, b);
        checkOutput(tag, lat, res, exc);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          rdyCount;
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
        bit          isMult;

        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        checkValue("reset.res", data_result, 32'd0);
        checkValue("reset.exc", {31'd0, data_exception}, 32'd0);
        checkValue("reset.rdy", {31'd0, data_resultRDY}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        applyStimulus(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        checkOutput("mul7xm3", 33, 32'hFFFF_FFEB, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        checkOutput("mulovf", 33, 32'h0000_0000, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h8000_0000, 32'd1);
        checkOutput("mulmin", 33, 32'h8000_0000, 1'b0);

        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        checkOutput("divm7by2", 34, 32'hFFFF_FFFD, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'd100, 32'd7);
        checkOutput("div100by7", 34, 32'd14, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'd5, 32'd0);
        checkOutput("divzero", 1, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("divovf", 34, 32'h8000_0000, 1'b1);

        applyStimulus(1'b1, 1'b0, 32'd3, 32'd4);
        rdyCount = 0;
        repeat (9) begin
            if (data_resultRDY === 1'b1) rdyCount++;
            @(negedge clock);
        end
        checkValue("abort.early", 32'(rdyCount), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'd9, 32'd3);
        checkOutput("abort.div", 34, 32'd3, 1'b0);

        applyStimulus(1'b1, 1'b1, 32'd6, 32'd2);
        checkOutput("bothstart", 33, 32'd12, 1'b0);

        // A new start issued in the DONE cycle must launch the next operation.
        applyStimulus(1'b1, 1'b0, 32'd5, 32'd6);
        cyc = 1;
        while (data_resultRDY !== 1'b1 && cyc < 80) begin
            @(negedge clock);
            cyc++;
        end
        checkValue("chain.mul", data_result, 32'd30);
        applyStimulus(1'b0, 1'b1, 32'd100, 32'd7);
        checkOutput("chain.div", 34, 32'd14, 1'b0);

        applyStimulus(1'b1, 1'b0, 32'd1234, 32'd5678);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkValue("midreset.res", data_result, 32'd0);
        checkValue("midreset.exc", {31'd0, data_exception}, 32'd0);
        checkValue("midreset.rdy", {31'd0, data_resultRDY}, 32'd0);
        rdyCount = 0;
        repeat (50) begin
            if (data_resultRDY === 1'b1) rdyCount++;
            @(negedge clock);
        end
        checkValue("midreset.nordy", 32'(rdyCount), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd2, 32'd2);
        checkOutput("afterreset", 33, 32'd4, 1'b0);

        for (int i = 0; i < 24; i++) begin
            isMult = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = 32'(int'($urandom_range(0, 2000)) - 1000); b = 32'(int'($urandom_range(0, 60)) - 30); end
                2: begin a = $urandom; b = 32'd0; end
                3: begin a = 32'h8000_0000; b = $urandom; end
                4: begin a = $urandom; b = 32'($urandom_range(1, 15)); end
                default: begin a = $urandom; b = 32'(-int'($urandom_range(1, 15))); end
            endcase
            runModelOp($sformatf("rand%0d", i), isMult, a, b);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
